sr_multi_chain_ctrl: RTL and testbench
======================================

Name: sr_multi_chain_ctrl

Overview:
Multi-channel shift-register programmer/reader for chip configuration chains. It is the single-clock successor of the existing SR write/read path.
- Holds NCH independent WIDTH-bit transmit images, loaded by 16-bit word writes.
- Shifts all chains out in parallel on a shared divided clk_sr, with the load_sr strobe at the end.
- Captures each chain's old contents as they shift back in.
- Flags readback mismatch against the image written in the previous operation.
- Sits between the control interface (register writes/reads) and the chip pads.

Parameters:
- NCH, 4: number of parallel chains (1..16).
- WIDTH, 170: bits per chain (≥2).
- DIV_WIDTH, 6: width of div. Half-period H = 2**div clk_in cycles.
- SHIFT_DIRECTION, 1: 1 = MSB out first, 0 = LSB out first.
- Derived: NWORDS = ceil(WIDTH/16); WA_W = clog2(NWORDS); CA_W = max(1, clog2(NCH)).

Ports:
- clk_in  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level, sampled per cycle; begins an operation when idle.
- div  in  DIV_WIDTH  division exponent, latched at start.
- wr_en  in  1  write din into tx image word.
- wr_addr  in  CA_W+WA_W  {channel, word}.
- din  in  16  write data.
- rd_en  in  1  read rx image word.
- rd_addr  in  CA_W+WA_W  {channel, word}.
- dout  out  16  read data, 1-cycle latency.
- data_in  in  NCH  serial returns from the chains.
- clk_sr  out  1  shift clock to the chip.
- data_out  out  NCH  serial data to the chains.
- load_sr  out  1  load strobe.
- busy  out  1  operation in progress.
- done  out  1  1-cycle completion pulse.
- mismatch  out  NCH  per-chain readback ≠ shadow.
- shadow_valid  out  1  a shadow image exists.
- wr_err  out  1  sticky: a write was attempted while busy.

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0.
- tx, rx and shadow images cleared; FSM to IDLE.
- Applies mid-operation too: clk_sr, load_sr and data_out drop immediately.

Image access:
- Word k holds bits [16k+15:16k]. Bits ≥ WIDTH in the last word are ignored on write and read as 0.
- Out-of-range channel or word: write ignored, read returns 0.
- wr_en while busy: write ignored, wr_err set. wr_err clears on the next accepted start.
- rd_en: dout updates next cycle. dout holds its value when rd_en is low. Reads are allowed while busy and return the partially filled rx image.

Tick generator:
- Counter reloads at start; tick asserts every H cycles (div=0 gives a tick every cycle).

FSM (transitions on tick only, except IDLE):
- IDLE: start && !busy → SETUP.
  - Latch div; clk_sr=0; data_out = first bit of each chain; busy=1 from the next cycle.
- SETUP, after H cycles → SHIFT_HI: clk_sr=1 (chips shift on the rising edge).
- SHIFT_HI → SHIFT_LO: clk_sr=0.
  - Sample data_in into each rx image in shift order, so the first sampled bit lands at the position the first transmitted bit came from.
  - Bit counter increments.
  - If counter < WIDTH, drive the next tx bit; else → LOAD.
- LOAD: load_sr=1, clk_sr=0, for 2H cycles → FINISH.
- FINISH, 1 cycle, then IDLE:
  - busy=0, done=1.
  - mismatch[i] = shadow_valid && (rx[i] ≠ shadow[i]).
  - shadow ← tx; shadow_valid ← 1.
- Timing: busy is high for exactly (2·WIDTH+3)·H cycles.

Other rules:
- start held high continuously retriggers only after returning to IDLE. No back-to-back overlap.
- div changes during an operation have no effect.
- mismatch holds until the next FINISH or reset.

Decomposition:
- Package sr_chain_pkg: FSM state enum (IDLE, SETUP, SHIFT_HI, SHIFT_LO, LOAD, FINISH), NWORDS/address-width functions, constant WORD_W=16.
- One sub-module: sr_tick_gen (div latch plus reload counter producing tick).
- Image arrays stay in the top module.

Test Plan:
- Reset then idle → all outputs 0; reading any address gives dout=0.
- NCH=2, WIDTH=8, div=0: write ch0=0xA5 and ch1=0x3C, start.
  - busy high 19 cycles.
  - data_out[0] presents 1,0,1,0,0,1,0,1 on the clk_sr rising edges (MSB first).
  - load_sr high 2 cycles; done pulse at cycle 20.
- Loopback (data_in = chain model delayed 8 bits), first run → shadow_valid=1, mismatch=0.
  - Second run with the same image → rx reads back 0xA5/0x3C, mismatch=00.
  - Third run with ch1 changed to 0x00 → mismatch=00, because the old 0x3C returns and matches the shadow. Corrupting one model bit of ch0 → mismatch[0]=1.
- div=2 (H=4): busy lasts 76 cycles; each clk_sr phase is 4 cycles. Changing div mid-run does not alter timing.
- wr_en during busy → tx image unchanged, wr_err=1; next start clears wr_err.
- rst_n pulled low mid-SHIFT → clk_sr, load_sr, busy and data_out at 0 immediately. After release, readback is 0 and shadow_valid=0.

Source files
------------

// File: rtl/sr_chain_pkg.sv
// Shared types and sizing helpers for the shift-register chain controller.
package sr_chain_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    LOAD,
    FINISH
  } sr_state_t;

  function automatic int calc_nwords(input int width);
    return (width + WORD_W - 1) / WORD_W;
  endfunction

  // A zero-width word field is legal: with a single word the address is just the channel.
  function automatic int calc_wa_w(input int nwords);
    return $clog2(nwords);
  endfunction

  function automatic int calc_ca_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sr_tick_gen.sv
// Divided-rate tick source: tick fires once every 2**div cycles, restarting on load.
module sr_tick_gen #(
  parameter int DIV_WIDTH = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam int CNT_W = 2 ** DIV_WIDTH;

  logic [DIV_WIDTH-1:0] div_q;
  logic [CNT_W-1:0]     cnt;

  function automatic logic [CNT_W-1:0] reload_val(input logic [DIV_WIDTH-1:0] d);
    return (CNT_W'(1) << d) - CNT_W'(1);
  endfunction

  // div is captured only on load so mid-operation changes cannot disturb the shift timing.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= reload_val(div);
    end else if (cnt == '0) begin
      cnt   <= reload_val(div_q);
    end else begin
      cnt   <= cnt - CNT_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sr_multi_chain_ctrl.sv
// Programs NCH configuration chains in parallel over a divided clk_sr and
// captures the returning contents for readback and shadow comparison.
module sr_multi_chain_ctrl
  import sr_chain_pkg::*;
#(
  parameter int NCH             = 4,
  parameter int WIDTH           = 170,
  parameter int DIV_WIDTH       = 6,
  parameter int SHIFT_DIRECTION = 1,
  localparam int NWORDS = calc_nwords(WIDTH),
  localparam int WA_W   = calc_wa_w(NWORDS),
  localparam int CA_W   = calc_ca_w(NCH),
  localparam int AW     = CA_W + WA_W
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [15:0]          din,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [15:0]          dout,
  input  logic [NCH-1:0]       data_in,
  output logic                 clk_sr,
  output logic [NCH-1:0]       data_out,
  output logic                 load_sr,
  output logic                 busy,
  output logic                 done,
  output logic [NCH-1:0]       mismatch,
  output logic                 shadow_valid,
  output logic                 wr_err
);

  localparam int PADW = NWORDS * WORD_W;
  localparam int BC_W = $clog2(WIDTH + 1);
  localparam int IX_W = $clog2(PADW);
  localparam logic [AW-1:0] WORD_MASK = AW'((1 << WA_W) - 1);

  // Images are padded to whole words; pad bits are never written and stay 0.
  logic [PADW-1:0] tx_img     [NCH];
  logic [PADW-1:0] rx_img     [NCH];
  logic [PADW-1:0] shadow_img [NCH];

  sr_state_t       state;
  logic [BC_W-1:0] bit_cnt;
  logic            load_half;
  logic            tick;
  logic            start_ok;
  logic [AW-1:0]   wr_ch, wr_wd, rd_ch, rd_wd;

  assign start_ok = (state == IDLE) && start && !busy;
  assign wr_ch    = wr_addr >> WA_W;
  assign wr_wd    = wr_addr & WORD_MASK;
  assign rd_ch    = rd_addr >> WA_W;
  assign rd_wd    = rd_addr & WORD_MASK;

  sr_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (start_ok),
    .div    (div),
    .tick   (tick)
  );

  // Image position of the n-th bit on the wire.
  function automatic logic [IX_W-1:0] bit_pos(input logic [BC_W-1:0] n);
    if (SHIFT_DIRECTION != 0) return IX_W'(WIDTH - 1 - int'(n));
    return IX_W'(n);
  endfunction

  function automatic logic [WORD_W-1:0] word_mask(input int k);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_W; b++) m[b] = (k * WORD_W + b) < WIDTH;
    return m;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) tx_img[c] <= '0;
      wr_err <= 1'b0;
    end else begin
      if (wr_en && busy) wr_err <= 1'b1;
      else if (start_ok) wr_err <= 1'b0;
      if (wr_en && !busy) begin
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < NWORDS; k++)
            if (wr_ch == AW'(c) && wr_wd == AW'(k))
              tx_img[c][k*WORD_W +: WORD_W] <= din & word_mask(k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NWORDS; k++)
          if (rd_ch == AW'(c) && rd_wd == AW'(k))
            dout <= rx_img[c][k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      load_half    <= 1'b0;
      clk_sr       <= 1'b0;
      load_sr      <= 1'b0;
      data_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch     <= '0;
      shadow_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        rx_img[c]     <= '0;
        shadow_img[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= SETUP;
            busy    <= 1'b1;
            clk_sr  <= 1'b0;
            bit_cnt <= '0;
            for (int c = 0; c < NCH; c++) data_out[c] <= tx_img[c][bit_pos('0)];
          end
        end
        SETUP: begin
          if (tick) begin
            state  <= SHIFT_HI;
            clk_sr <= 1'b1;
          end
        end
        SHIFT_HI: begin
          // Falling edge: capture the returned bit and present the next one.
          if (tick) begin
            state   <= SHIFT_LO;
            clk_sr  <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            for (int c = 0; c < NCH; c++) rx_img[c][bit_pos(bit_cnt)] <= data_in[c];
            if (int'(bit_cnt) + 1 < WIDTH)
              for (int c = 0; c < NCH; c++)
                data_out[c] <= tx_img[c][bit_pos(bit_cnt + 1'b1)];
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            if (int'(bit_cnt) < WIDTH) begin
              state  <= SHIFT_HI;
              clk_sr <= 1'b1;
            end else begin
              state     <= LOAD;
              load_sr   <= 1'b1;
              load_half <= 1'b0;
              data_out  <= '0;
            end
          end
        end
        LOAD: begin
          if (tick) begin
            if (!load_half) begin
              load_half <= 1'b1;
            end else begin
              state        <= FINISH;
              load_sr      <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              shadow_valid <= 1'b1;
              for (int c = 0; c < NCH; c++) begin
                mismatch[c]   <= shadow_valid && (rx_img[c] != shadow_img[c]);
                shadow_img[c] <= tx_img[c];
              end
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_multi_chain_ctrl.sv
// Directed bench for sr_multi_chain_ctrl: 2 chains of 8 bits looped back
// through a chip model that returns each bit 8 clk_sr rises later.
module tb_sr_multi_chain_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  div;
  logic        wr_en;
  logic [0:0]  wr_addr;
  logic [15:0] din;
  logic        rd_en;
  logic [0:0]  rd_addr;
  logic [15:0] dout;
  logic [1:0]  data_in;
  logic        clk_sr;
  logic [1:0]  data_out;
  logic        load_sr;
  logic        busy;
  logic        done;
  logic [1:0]  mismatch;
  logic        shadow_valid;
  logic        wr_err;

  int total = 0;
  int bad   = 0;

  logic [8:0] chip [2];

  sr_multi_chain_ctrl #(
    .NCH(2), .WIDTH(8), .DIV_WIDTH(6), .SHIFT_DIRECTION(1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .div(div),
    .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout),
    .data_in(data_in), .clk_sr(clk_sr), .data_out(data_out),
    .load_sr(load_sr), .busy(busy), .done(done), .mismatch(mismatch),
    .shadow_valid(shadow_valid), .wr_err(wr_err)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // chip model: shifts on the rising clk_sr edge, returns bit shifted in 8 rises ago
  always @(posedge clk_sr) begin
    for (int c = 0; c < 2; c++) chip[c] <= {chip[c][7:0], data_out[c]};
  end
  assign data_in = {chip[1][8], chip[0][8]};

  // driver tasks
  task automatic do_write(input logic [0:0] a, input logic [15:0] d);
    @(negedge clk_in);
    wr_en = 1'b1; wr_addr = a; din = d;
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [0:0] a, output logic [15:0] d);
    @(negedge clk_in);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk_in);
    rd_en = 1'b0;
    d = dout;
  endtask

  // Starts an operation and samples every cycle until done or a 2000-cycle budget.
  task automatic run_op(input logic [5:0] d, input logic [5:0] d_mid, input bit wr_mid,
                        output int busy_n, output int hi_n, output int rise_n,
                        output int load_n, output int done_at,
                        output logic [7:0] b0, output logic [7:0] b1,
                        output logic err_first);
    logic prev_sr;
    busy_n = 0; hi_n = 0; rise_n = 0; load_n = 0; done_at = -1;
    b0 = '0; b1 = '0; prev_sr = 1'b0;
    @(negedge clk_in);
    div = d; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0; div = d_mid;
    err_first = wr_err;
    if (wr_mid) begin wr_en = 1'b1; wr_addr = 1'b0; din = 16'hFFFF; end
    for (int n = 1; n <= 2000 && done_at < 0; n++) begin
      if (n == 2) wr_en = 1'b0;
      if (busy) busy_n++;
      if (clk_sr) hi_n++;
      if (load_sr) load_n++;
      if (clk_sr && !prev_sr) begin
        rise_n++;
        b0 = {b0[6:0], data_out[0]};
        b1 = {b1[6:0], data_out[1]};
      end
      prev_sr = clk_sr;
      if (done) done_at = n;
      else @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0; start = 1'b0; div = '0; wr_en = 1'b0; wr_addr = '0;
    din = '0; rd_en = 1'b0; rd_addr = '0;
    chip[0] = '0; chip[1] = '0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    total++; if ({clk_sr, load_sr, busy, done} !== 4'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {clk_sr, load_sr, busy, done}); end
    total++; if (data_out !== 2'b00) begin bad++;
      $display("FAIL reset_data_out: got %b want 00", data_out); end
    total++; if ({mismatch, shadow_valid, wr_err} !== 4'b0) begin bad++;
      $display("FAIL reset_status: got %b want 0000", {mismatch, shadow_valid, wr_err}); end
    total++; if (dout !== 16'h0) begin bad++;
      $display("FAIL reset_dout: got %h want 0000", dout); end
    do_read(1'b0, d);
    total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_read0: got %h want 0000", d); end
    do_read(1'b1, d);
    total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_read1: got %h want 0000", d); end
  endtask

  task automatic test_basic_run();
    int bn, hn, rn, ln, da;
    logic [7:0] b0, b1;
    logic ef;
    do_write(1'b0, 16'h12A5);
    do_write(1'b1, 16'h003C);
    run_op(6'd0, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (bn != 19) begin bad++; $display("FAIL basic_busy: got %0d want 19", bn); end
    total++; if (da != 20) begin bad++; $display("FAIL basic_done_at: got %0d want 20", da); end
    total++; if (rn != 8) begin bad++; $display("FAIL basic_rises: got %0d want 8", rn); end
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL basic_bits_ch0: got %h want a5", b0); end
    total++; if (b1 !== 8'h3C) begin bad++; $display("FAIL basic_bits_ch1: got %h want 3c", b1); end
    total++; if (ln != 2) begin bad++; $display("FAIL basic_load_len: got %0d want 2", ln); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    total++; if ({shadow_valid, mismatch} !== 3'b100) begin bad++;
      $display("FAIL first_run_status: got %b want 100", {shadow_valid, mismatch}); end
    @(negedge clk_in);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_loopback();
    int bn, hn, rn, ln, da;
    logic [7:0] b0, b1;
    logic ef;
    logic [15:0] d;
    run_op(6'd0, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (mismatch !== 2'b00) begin bad++; $display("FAIL run2_mismatch: got %b want 00", mismatch); end
    do_read(1'b0, d);
    total++; if (d !== 16'h00A5) begin bad++; $display("FAIL run2_rx0: got %h want 00a5", d); end
    repeat (2) @(negedge clk_in);
    total++; if (dout !== 16'h00A5) begin bad++; $display("FAIL dout_hold: got %h want 00a5", dout); end
    do_read(1'b1, d);
    total++; if (d !== 16'h003C) begin bad++; $display("FAIL run2_rx1: got %h want 003c", d); end
    do_write(1'b1, 16'h0000);
    run_op(6'd0, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (b1 !== 8'h00) begin bad++; $display("FAIL run3_bits_ch1: got %h want 00", b1); end
    total++; if (mismatch !== 2'b00) begin bad++; $display("FAIL run3_mismatch: got %b want 00", mismatch); end
    do_read(1'b1, d);
    total++; if (d !== 16'h003C) begin bad++; $display("FAIL run3_rx1: got %h want 003c", d); end
    chip[0][3] = ~chip[0][3];
    run_op(6'd0, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (mismatch !== 2'b01) begin bad++; $display("FAIL run4_mismatch: got %b want 01", mismatch); end
    do_read(1'b0, d);
    total++; if (d !== 16'h00AD) begin bad++; $display("FAIL run4_rx0: got %h want 00ad", d); end
    repeat (5) @(negedge clk_in);
    total++; if (mismatch !== 2'b01) begin bad++; $display("FAIL mismatch_hold: got %b want 01", mismatch); end
  endtask

  task automatic test_div();
    int bn, hn, rn, ln, da;
    logic [7:0] b0, b1;
    logic ef;
    run_op(6'd2, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (bn != 76) begin bad++; $display("FAIL div2_busy: got %0d want 76", bn); end
    total++; if (hn != 32) begin bad++; $display("FAIL div2_clk_sr_high: got %0d want 32", hn); end
    total++; if (ln != 8) begin bad++; $display("FAIL div2_load_len: got %0d want 8", ln); end
    total++; if (da != 77) begin bad++; $display("FAIL div2_done_at: got %0d want 77", da); end
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL div2_bits_ch0: got %h want a5", b0); end
    total++; if (mismatch !== 2'b00) begin bad++; $display("FAIL div2_mismatch: got %b want 00", mismatch); end
  endtask

  task automatic test_wr_err();
    int bn, hn, rn, ln, da;
    logic [7:0] b0, b1;
    logic ef;
    run_op(6'd1, 6'd1, 1'b1, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (bn != 38) begin bad++; $display("FAIL div1_busy: got %0d want 38", bn); end
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_set: got %b want 1", wr_err); end
    repeat (3) @(negedge clk_in);
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_sticky: got %b want 1", wr_err); end
    run_op(6'd0, 6'd0, 1'b0, bn, hn, rn, ln, da, b0, b1, ef);
    total++; if (ef !== 1'b0) begin bad++; $display("FAIL wr_err_clear: got %b want 0", ef); end
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL tx_unchanged: got %h want a5", b0); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    @(negedge clk_in);
    div = 6'd2; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    for (int i = 0; i < 200 && !clk_sr; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    total++; if ({clk_sr, busy} !== 2'b11) begin bad++;
      $display("FAIL areset_pre_shift: got %b want 11", {clk_sr, busy}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({clk_sr, load_sr, busy} !== 3'b000) begin bad++;
      $display("FAIL areset_ctrl: got %b want 000", {clk_sr, load_sr, busy}); end
    total++; if (data_out !== 2'b00) begin bad++;
      $display("FAIL areset_data_out: got %b want 00", data_out); end
    @(negedge clk_in);
    rst_n = 1'b1;
    do_read(1'b0, d);
    total++; if (d !== 16'h0) begin bad++; $display("FAIL areset_read0: got %h want 0000", d); end
    do_read(1'b1, d);
    total++; if (d !== 16'h0) begin bad++; $display("FAIL areset_read1: got %h want 0000", d); end
    total++; if ({shadow_valid, mismatch} !== 3'b000) begin bad++;
      $display("FAIL areset_status: got %b want 000", {shadow_valid, mismatch}); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_loopback();
    test_div();
    test_wr_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
